// File: rtl/axi_rand_range_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axirand_pkg
// Description : Shared constants and state encoding for axi_rand_range.
//               DEF_WIDTH - default width of limit/random/result words
//               REJ_WIDTH - width of the saturating reject counter
//               state_t   - IDLE (no limit loaded) / RUN
// Revision    : 1.0 - initial release
// ============================================================================
package axirand_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int REJ_WIDTH = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_rand_range_if.sv
`default_nettype none
// ============================================================================
// Interface   : axi_rand_range_if
// Description : Limit, random and result channels of axi_rand_range.
//               ldata/ldatavalid/ldataready - range limit N channel
//               sdata/sdatavalid/sdataready - raw random word channel
//               rdata/rdatavalid/rdataready - range-reduced result channel
//               rejects                     - rejected words since last load
//               modport slave  : the range reducer
//               modport master : the environment driving it
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_rand_range_if
    import axirand_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0]     ldata;
    logic                 ldatavalid;
    logic                 ldataready;
    logic [WIDTH-1:0]     sdata;
    logic                 sdatavalid;
    logic                 sdataready;
    logic [WIDTH-1:0]     rdata;
    logic                 rdatavalid;
    logic                 rdataready;
    logic [REJ_WIDTH-1:0] rejects;

    modport slave (
        input  ldata, ldatavalid, sdata, sdatavalid, rdataready,
        output ldataready, sdataready, rdata, rdatavalid, rejects
    );

    modport master (
        output ldata, ldatavalid, sdata, sdatavalid, rdataready,
        input  ldataready, sdataready, rdata, rdatavalid, rejects
    );

endinterface
`default_nettype wire

// File: rtl/axi_rand_range_mask.sv
`default_nettype none
// ============================================================================
// Module      : range_mask
// Description : Combinational smear: every output bit at or below the most
//               significant set bit of the input is set.
//               value - input word
//               mask  - smeared word
// Revision    : 1.0 - initial release
// ============================================================================
module range_mask #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] mask
);

    // Bit i is set when any input bit at position i or above is set.
    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = |(value >> i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rand_range.sv
`default_nettype none
// ============================================================================
// Module      : axi_rand_range
// Description : Reduces raw random words into [0,N) by masking and
//               rejection. A limit N is loaded over the limit channel; each
//               consumed random word is ANDed with smear(N-1) and accepted
//               when below N (N=0 accepts everything). Accepted words appear
//               one cycle after consumption; rejected words bump a
//               saturating counter.
//               clk   - clock, rising edge
//               anrst - asynchronous active-low reset
//               bus   - limit / random / result channels (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rand_range
    import axirand_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                anrst,
    axi_rand_range_if.slave     bus
);

    state_t               state;
    state_t               next_state;
    logic [WIDTH-1:0]     limit;
    logic [WIDTH-1:0]     mask;
    logic [WIDTH-1:0]     new_mask;
    logic [WIDTH-1:0]     rdata;
    logic                 rdatavalid;
    logic [REJ_WIDTH-1:0] rejects;
    logic                 ldataready;
    logic                 sdataready;
    logic                 load_hs;
    logic                 take_hs;
    logic                 out_hs;
    logic [WIDTH-1:0]     candidate;
    logic                 accept;

    // smear(N-1): N=0 wraps to all ones, N=1 gives zero.
    range_mask #(
        .WIDTH (WIDTH)
    ) u_range_mask (
        .value (bus.ldata - WIDTH'(1)),
        .mask  (new_mask)
    );

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ldataready = 1'b1;
        sdataready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.ldatavalid) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // A pending result keeps the old limit in force until it
                // drains; a limit offer takes precedence over random words.
                ldataready = !rdatavalid;
                sdataready = !bus.ldatavalid && (!rdatavalid || bus.rdataready);
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign load_hs   = bus.ldatavalid & ldataready;
    assign take_hs   = bus.sdatavalid & sdataready;
    assign out_hs    = rdatavalid & bus.rdataready;
    assign candidate = bus.sdata & mask;
    assign accept    = (limit == '0) || (candidate < limit);

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            limit      <= '0;
            mask       <= '0;
            rdata      <= '0;
            rdatavalid <= 1'b0;
            rejects    <= '0;
        end else begin
            if (out_hs) begin
                rdatavalid <= 1'b0;
            end
            if (load_hs) begin
                limit   <= bus.ldata;
                mask    <= new_mask;
                rejects <= '0;
            end else if (take_hs) begin
                if (accept) begin
                    rdata      <= candidate;
                    rdatavalid <= 1'b1;
                end else if (rejects != {REJ_WIDTH{1'b1}}) begin
                    rejects <= rejects + REJ_WIDTH'(1);
                end
            end
        end
    end

    assign bus.ldataready = ldataready;
    assign bus.sdataready = sdataready;
    assign bus.rdata      = rdata;
    assign bus.rdatavalid = rdatavalid;
    assign bus.rejects    = rejects;

endmodule
`default_nettype wire
